// File: rtl/sys_ctrl.sv
// -----------------------------------------------------------------------------
// sys_ctrl
// Command decoder / sequencer in the REF_CLK domain. Parses frames arriving
// byte by byte from the UART receiver, drives the register file and the ALU,
// and pushes response bytes (read data, or the 2-byte ALU result low byte
// first) into the write port of the TX async FIFO.
//
// Frames (first byte seen in IDLE selects the command):
//   0xAA addr data    register-file write
//   0xBB addr         register-file read, one response byte
//   0xCC A B fun      write A->reg0, B->reg1, run ALU, two response bytes
//   0xDD fun          run ALU on current operands, two response bytes
//   any other byte in IDLE is dropped.
//
// Ports
//   CLK, RST              REF_CLK and async active-low reset
//   RX_P_DATA, RX_D_VLD   received byte and its 1-cycle valid strobe
//   RF_*                  register-file address/strobes/data and read return
//   ALU_EN, ALU_FUN       ALU operate strobe and function code
//   CLK_GATE_EN           ALU clock-gate enable, high while an op is pending
//   ALU_OUT, ALU_OUT_VLD  ALU result and its valid strobe
//   WR_DATA, W_INC, FULL  FIFO write data, write strobe and full flag
//
// Every output is a flop. Strobes are 1 cycle wide; data/address/function
// outputs hold their last value between strobes.
// -----------------------------------------------------------------------------
module sys_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]     RF_Address,
    output logic                      RF_WrEn,
    output logic                      RF_RdEn,
    output logic [DATA_WIDTH-1:0]     RF_WrData,
    input  logic [DATA_WIDTH-1:0]     RF_RdData,
    input  logic                      RF_RdData_Vaild,
    output logic                      ALU_EN,
    output logic [FUN_WIDTH-1:0]      ALU_FUN,
    output logic                      CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]     WR_DATA,
    output logic                      W_INC,
    input  logic                      FULL
);

    localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] OP_RF_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RF_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

    // ALU operands live at fixed register-file locations
    localparam logic [ADDR_WIDTH-1:0] ADDR_OPA = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OPB = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_SEND_RD  = 4'd5,
        S_ALU_OPA  = 4'd6,
        S_ALU_OPB  = 4'd7,
        S_ALU_FUN  = 4'd8,
        S_ALU_WAIT = 4'd9,
        S_SEND_LO  = 4'd10,
        S_SEND_HI  = 4'd11
    } state_e;

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,   rd_data_d;
    logic [RES_WIDTH-1:0]    result_q,    result_d;

    logic [ADDR_WIDTH-1:0]   rf_addr_q,   rf_addr_d;
    logic                    rf_wren_q,   rf_wren_d;
    logic                    rf_rden_q,   rf_rden_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q,  rf_wdata_d;
    logic                    alu_en_q,    alu_en_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q,   alu_fun_d;
    logic                    cg_en_q,     cg_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q,   wr_data_d;
    logic                    w_inc_q,     w_inc_d;

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        result_d   = result_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        alu_fun_d  = alu_fun_q;
        cg_en_d    = cg_en_q;
        wr_data_d  = wr_data_q;
        rf_wren_d  = 1'b0;
        rf_rden_d  = 1'b0;
        alu_en_d   = 1'b0;
        w_inc_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_RF_WR) begin
                        state_d = S_WR_ADDR;
                    end else if (RX_P_DATA == OP_RF_RD) begin
                        state_d = S_RD_ADDR;
                    end else if (RX_P_DATA == OP_ALU_OP) begin
                        state_d = S_ALU_OPA;
                    end else if (RX_P_DATA == OP_ALU_NO) begin
                        state_d = S_ALU_FUN;
                    end
                end
            end

            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wren_d  = 1'b1;
                    rf_addr_d  = addr_q;
                    rf_wdata_d = RX_P_DATA;
                    state_d    = S_IDLE;
                end
            end

            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rden_d = 1'b1;
                    rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = S_RD_WAIT;
                end
            end

            // Bytes arriving while waiting or sending are dropped, not queued
            S_RD_WAIT: begin
                if (RF_RdData_Vaild) begin
                    rd_data_d = RF_RdData;
                    state_d   = S_SEND_RD;
                end
            end

            // FULL stalls here with WR_DATA untouched; the byte is never lost
            S_SEND_RD: begin
                if (!FULL) begin
                    w_inc_d   = 1'b1;
                    wr_data_d = rd_data_q;
                    state_d   = S_IDLE;
                end
            end

            S_ALU_OPA: begin
                if (RX_D_VLD) begin
                    rf_wren_d  = 1'b1;
                    rf_addr_d  = ADDR_OPA;
                    rf_wdata_d = RX_P_DATA;
                    state_d    = S_ALU_OPB;
                end
            end

            S_ALU_OPB: begin
                if (RX_D_VLD) begin
                    rf_wren_d  = 1'b1;
                    rf_addr_d  = ADDR_OPB;
                    rf_wdata_d = RX_P_DATA;
                    state_d    = S_ALU_FUN;
                end
            end

            // Clock gate opens together with the operate strobe
            S_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                    cg_en_d   = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end

            S_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_d = ALU_OUT;
                    cg_en_d  = 1'b0;
                    state_d  = S_SEND_LO;
                end
            end

            S_SEND_LO: begin
                if (!FULL) begin
                    w_inc_d   = 1'b1;
                    wr_data_d = result_q[DATA_WIDTH-1:0];
                    state_d   = S_SEND_HI;
                end
            end

            S_SEND_HI: begin
                if (!FULL) begin
                    w_inc_d   = 1'b1;
                    wr_data_d = result_q[RES_WIDTH-1:DATA_WIDTH];
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched operands and output flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_data_q  <= '0;
            result_q   <= '0;
            rf_addr_q  <= '0;
            rf_wren_q  <= 1'b0;
            rf_rden_q  <= 1'b0;
            rf_wdata_q <= '0;
            alu_en_q   <= 1'b0;
            alu_fun_q  <= '0;
            cg_en_q    <= 1'b0;
            wr_data_q  <= '0;
            w_inc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            result_q   <= result_d;
            rf_addr_q  <= rf_addr_d;
            rf_wren_q  <= rf_wren_d;
            rf_rden_q  <= rf_rden_d;
            rf_wdata_q <= rf_wdata_d;
            alu_en_q   <= alu_en_d;
            alu_fun_q  <= alu_fun_d;
            cg_en_q    <= cg_en_d;
            wr_data_q  <= wr_data_d;
            w_inc_q    <= w_inc_d;
        end
    end

    assign RF_Address  = rf_addr_q;
    assign RF_WrEn     = rf_wren_q;
    assign RF_RdEn     = rf_rden_q;
    assign RF_WrData   = rf_wdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = cg_en_q;
    assign WR_DATA     = wr_data_q;
    assign W_INC       = w_inc_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl
// Bench for sys_ctrl. The bench plays UART RX, the register file and the ALU.
// Expected register writes, reads, ALU launches and FIFO bytes are queued when
// a frame is driven and checked off by a monitor on the falling edge whenever
// the matching strobe shows up.
// -----------------------------------------------------------------------------
module tb_sys_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [DW-1:0]   RX_P_DATA;
    logic            RX_D_VLD;
    logic [AW-1:0]   RF_Address;
    logic            RF_WrEn;
    logic            RF_RdEn;
    logic [DW-1:0]   RF_WrData;
    logic [DW-1:0]   RF_RdData;
    logic            RF_RdData_Vaild;
    logic            ALU_EN;
    logic [FW-1:0]   ALU_FUN;
    logic            CLK_GATE_EN;
    logic [2*DW-1:0] ALU_OUT;
    logic            ALU_OUT_VLD;
    logic [DW-1:0]   WR_DATA;
    logic            W_INC;
    logic            FULL;

    always #5 CLK = ~CLK;

    sys_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FUN_WIDTH (FW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_P_DATA      (RX_P_DATA),
        .RX_D_VLD       (RX_D_VLD),
        .RF_Address     (RF_Address),
        .RF_WrEn        (RF_WrEn),
        .RF_RdEn        (RF_RdEn),
        .RF_WrData      (RF_WrData),
        .RF_RdData      (RF_RdData),
        .RF_RdData_Vaild(RF_RdData_Vaild),
        .ALU_EN         (ALU_EN),
        .ALU_FUN        (ALU_FUN),
        .CLK_GATE_EN    (CLK_GATE_EN),
        .ALU_OUT        (ALU_OUT),
        .ALU_OUT_VLD    (ALU_OUT_VLD),
        .WR_DATA        (WR_DATA),
        .W_INC          (W_INC),
        .FULL           (FULL)
    );

    int checks   = 0;
    int errors   = 0;
    int winc_cnt = 0;

    // Scoreboard queues
    logic [11:0] wr_q[$];   // {addr, data}
    logic [3:0]  rd_q[$];   // read address
    logic [3:0]  alu_q[$];  // function code
    logic [7:0]  out_q[$];  // FIFO bytes in order

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  f;
        logic [15:0] ret;     // value returned by RF (low byte) or ALU
        logic [3:0]  e_addr;  // expected RF address (AA write / BB read)
        logic [7:0]  e_data;  // expected RF write data (AA)
        logic [3:0]  e_fun;   // expected ALU_FUN
        logic [7:0]  e_lo;    // expected first FIFO byte
        logic [7:0]  e_hi;    // expected second FIFO byte (ALU only)
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got strobe with value 0x%0h expected no strobe", name, act);
    endfunction

    function automatic bit pending();
        return (wr_q.size() != 0) || (rd_q.size() != 0) || (alu_q.size() != 0) || (out_q.size() != 0);
    endfunction

    // Strobe monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WrEn || RF_RdEn)
                chk("wr_rd_exclusive", 32'(RF_WrEn & RF_RdEn), 32'd0);
            if (RF_WrEn) begin
                if (wr_q.size() == 0) unexpected("rf_write_unexpected", 32'({RF_Address, RF_WrData}));
                else chk("rf_write", 32'({RF_Address, RF_WrData}), 32'(wr_q.pop_front()));
            end
            if (RF_RdEn) begin
                if (rd_q.size() == 0) unexpected("rf_read_unexpected", 32'(RF_Address));
                else chk("rf_read_addr", 32'(RF_Address), 32'(rd_q.pop_front()));
            end
            if (ALU_EN) begin
                chk("cg_with_alu_en", 32'(CLK_GATE_EN), 32'd1);
                if (alu_q.size() == 0) unexpected("alu_en_unexpected", 32'(ALU_FUN));
                else chk("alu_fun", 32'(ALU_FUN), 32'(alu_q.pop_front()));
            end
            if (W_INC) begin
                winc_cnt++;
                if (out_q.size() == 0) unexpected("fifo_write_unexpected", 32'(WR_DATA));
                else chk("fifo_byte", 32'(WR_DATA), 32'(out_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        tick();
    endtask

    task automatic rf_return(input logic [7:0] d);
        RF_RdData       = d;
        RF_RdData_Vaild = 1'b1;
        tick();
        RF_RdData_Vaild = 1'b0;
    endtask

    task automatic alu_return(input logic [15:0] r);
        chk("cg_while_pending", 32'(CLK_GATE_EN), 32'd1);
        ALU_OUT     = r;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        chk("cg_after_result", 32'(CLK_GATE_EN), 32'd0);
    endtask

    // Bounded wait for every expected event to be seen
    task automatic drain(input string name);
        int n = 0;
        while (pending() && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s_timeout: got wr=%0d rd=%0d alu=%0d out=%0d outstanding expected 0",
                     name, wr_q.size(), rd_q.size(), alu_q.size(), out_q.size());
            wr_q.delete(); rd_q.delete(); alu_q.delete(); out_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        case (v.op)
            8'hAA: begin
                wr_q.push_back({v.e_addr, v.e_data});
                send_byte(v.op); send_byte(v.a); send_byte(v.b);
            end
            8'hBB: begin
                rd_q.push_back(v.e_addr);
                out_q.push_back(v.e_lo);
                send_byte(v.op); send_byte(v.a);
                rf_return(v.ret[7:0]);
            end
            8'hCC: begin
                wr_q.push_back({4'h0, v.a});
                wr_q.push_back({4'h1, v.b});
                alu_q.push_back(v.e_fun);
                out_q.push_back(v.e_lo);
                out_q.push_back(v.e_hi);
                send_byte(v.op); send_byte(v.a); send_byte(v.b); send_byte(v.f);
                alu_return(v.ret);
            end
            8'hDD: begin
                alu_q.push_back(v.e_fun);
                out_q.push_back(v.e_lo);
                out_q.push_back(v.e_hi);
                send_byte(v.op); send_byte(v.f);
                alu_return(v.ret);
            end
            default: send_byte(v.op);
        endcase
        drain("vector");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;

        //            op     a      b      f      ret       addr  data   fun   lo     hi
        vecs[0] = '{8'hAA, 8'h05, 8'h3C, 8'h00, 16'h0000, 4'h5, 8'h3C, 4'h0, 8'h00, 8'h00};
        vecs[1] = '{8'hBB, 8'h02, 8'h00, 8'h00, 16'h007E, 4'h2, 8'h00, 4'h0, 8'h7E, 8'h00};
        vecs[2] = '{8'hCC, 8'h03, 8'h04, 8'h00, 16'h0007, 4'h0, 8'h00, 4'h0, 8'h07, 8'h00};
        vecs[3] = '{8'hAA, 8'h1F, 8'hA5, 8'h00, 16'h0000, 4'hF, 8'hA5, 4'h0, 8'h00, 8'h00};
        vecs[4] = '{8'hDD, 8'h00, 8'h00, 8'h13, 16'hBEEF, 4'h0, 8'h00, 4'h3, 8'hEF, 8'hBE};
        vecs[5] = '{8'hBB, 8'h0F, 8'h00, 8'h00, 16'h0000, 4'hF, 8'h00, 4'h0, 8'h00, 8'h00};
        vecs[6] = '{8'hCC, 8'hFF, 8'h80, 8'h0A, 16'h807F, 4'h0, 8'h00, 4'hA, 8'h7F, 8'h80};
        vecs[7] = '{8'hAA, 8'h00, 8'h00, 8'h00, 16'h0000, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00};

        RST             = 1'b0;
        RX_P_DATA       = '0;
        RX_D_VLD        = 1'b0;
        RF_RdData       = '0;
        RF_RdData_Vaild = 1'b0;
        ALU_OUT         = '0;
        ALU_OUT_VLD     = 1'b0;
        FULL            = 1'b0;

        #12;
        chk("reset_strobes", 32'({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, W_INC}), 32'd0);
        chk("reset_data", 32'({RF_Address, RF_WrData, ALU_FUN, WR_DATA}), 32'd0);
        tick();
        RST = 1'b1;
        tick();
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // FIFO full while the ALU result waits: nothing written until released
        alu_q.push_back(4'h2);
        out_q.push_back(8'h34);
        out_q.push_back(8'h12);
        send_byte(8'hDD);
        send_byte(8'h02);
        FULL = 1'b1;
        alu_return(16'h1234);
        cnt0 = winc_cnt;
        repeat (10) tick();
        chk("no_winc_while_full", 32'(winc_cnt), 32'(cnt0));
        chk("bytes_held_while_full", 32'(out_q.size()), 32'd2);
        FULL = 1'b0;
        drain("full_release");
        chk("winc_after_full", 32'(winc_cnt), 32'(cnt0 + 2));

        // Reset in the middle of an ALU frame, then a clean write
        wr_q.push_back({4'h0, 8'h03});
        send_byte(8'hCC);
        send_byte(8'h03);
        RST = 1'b0;
        #1;
        chk("midreset_strobes", 32'({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, W_INC}), 32'd0);
        chk("midreset_data", 32'({RF_Address, RF_WrData, ALU_FUN, WR_DATA}), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        wr_q.push_back({4'h1, 8'h11});
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h11);
        drain("after_reset");

        // Unknown opcode in IDLE is dropped; the following read is untouched
        rd_q.push_back(4'h0);
        out_q.push_back(8'hC3);
        send_byte(8'h55);
        send_byte(8'hBB);
        send_byte(8'h00);
        rf_return(8'hC3);
        drain("ignore_55");

        // A byte arriving while a read is outstanding is dropped
        rd_q.push_back(4'h3);
        out_q.push_back(8'h5A);
        send_byte(8'hBB);
        send_byte(8'h03);
        send_byte(8'hAA);
        rf_return(8'h5A);
        drain("ignore_in_wait");
        repeat (5) tick();
        chk("idle_after_ignore", 32'(winc_cnt), 32'(cnt0 + 4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
